// File: rtl/reg_writeback.sv
// Write-side front end for the register file: merges ALU results with queued
// long-latency completions onto the single write port, with WAW squash and hazard query.
module reg_writeback #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    AluWr,
   input  logic [4:0]              AluAddr,
   input  logic [DW-1:0]           AluData,
   input  logic                    MemWr,
   input  logic [4:0]              MemAddr,
   input  logic [DW-1:0]           MemData,
   output logic                    MemReady,
   input  logic [4:0]              QueryAddr,
   output logic                    Pending,
   output logic [$clog2(DEPTH):0]  Count,
   output logic [4:0]              WrAddr,
   output logic [DW-1:0]           DataIn,
   output logic                    RegWr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   rdPtr;
   logic [PW-1:0]   wrPtr;
   logic            validReg [DEPTH];
   logic [4:0]      addrReg  [DEPTH];
   logic [DW-1:0]   dataMem  [DEPTH];

   logic            aluAccept;
   logic            pushAccept;
   logic            headValid;
   logic            queueBusy;
   logic            drainSel;
   logic            squashSel;
   logic            popSel;
   logic [DEPTH-1:0] squashHit;
   logic [DEPTH-1:0] queryHit;

   assign MemReady   = (Count < CW'(DEPTH));
   assign aluAccept  = AluWr && (AluAddr != 5'd0);
   assign pushAccept = MemWr && MemReady && (MemAddr != 5'd0);
   assign headValid  = validReg[rdPtr];
   assign queueBusy  = (Count != '0);
   assign drainSel   = !aluAccept && queueBusy && headValid;
   assign squashSel  = !aluAccept && queueBusy && !headValid;
   assign popSel     = drainSel || squashSel;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
         assign squashHit[gi] = aluAccept && (addrReg[gi] == AluAddr);
         assign queryHit[gi]  = validReg[gi] && (addrReg[gi] == QueryAddr);

         // A push landing in this slot beats a same-cycle squash: the completion is newer.
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               validReg[gi] <= 1'b0;
               addrReg[gi]  <= 5'd0;
            end else if (pushAccept && (wrPtr == PW'(gi))) begin
               validReg[gi] <= 1'b1;
               addrReg[gi]  <= MemAddr;
            end else if (squashHit[gi] || (popSel && (rdPtr == PW'(gi)))) begin
               validReg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (pushAccept)
         dataMem[wrPtr] <= MemData;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdPtr  <= '0;
         wrPtr  <= '0;
         Count  <= '0;
         RegWr  <= 1'b0;
         WrAddr <= 5'd0;
         DataIn <= '0;
      end else begin
         if (pushAccept)
            wrPtr <= wrPtr + PW'(1);
         if (popSel)
            rdPtr <= rdPtr + PW'(1);
         Count <= Count + CW'(pushAccept) - CW'(popSel);

         if (aluAccept) begin
            RegWr  <= 1'b1;
            WrAddr <= AluAddr;
            DataIn <= AluData;
         end else if (drainSel) begin
            RegWr  <= 1'b1;
            WrAddr <= addrReg[rdPtr];
            DataIn <= dataMem[rdPtr];
         end else begin
            RegWr  <= 1'b0;
         end
      end
   end

   // Only registered state is consulted; same-cycle AluWr/MemWr are invisible here.
   assign Pending = (QueryAddr != 5'd0) &&
                    ((|queryHit) || (RegWr && (WrAddr == QueryAddr)));

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback (DEPTH=4, DW=32).
module tb_reg_writeback;

   logic        Clk;
   logic        Rst;
   logic        AluWr;
   logic [4:0]  AluAddr;
   logic [31:0] AluData;
   logic        MemWr;
   logic [4:0]  MemAddr;
   logic [31:0] MemData;
   logic        MemReady;
   logic [4:0]  QueryAddr;
   logic        Pending;
   logic [2:0]  Count;
   logic [4:0]  WrAddr;
   logic [31:0] DataIn;
   logic        RegWr;

   int vectors;
   int miscompares;

   reg_writeback #(.DEPTH(4), .DW(32)) dut (
      .Clk(Clk), .Rst(Rst),
      .AluWr(AluWr), .AluAddr(AluAddr), .AluData(AluData),
      .MemWr(MemWr), .MemAddr(MemAddr), .MemData(MemData),
      .MemReady(MemReady), .QueryAddr(QueryAddr), .Pending(Pending),
      .Count(Count), .WrAddr(WrAddr), .DataIn(DataIn), .RegWr(RegWr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic test_reset;
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL rst_regwr: got %0h want 0", RegWr); end
      vectors++; if (WrAddr !== 5'd0) begin miscompares++; $display("FAIL rst_wraddr: got %0h want 0", WrAddr); end
      vectors++; if (DataIn !== 32'd0) begin miscompares++; $display("FAIL rst_datain: got %0h want 0", DataIn); end
      vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", Count); end
      vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL rst_memready: got %0h want 1", MemReady); end
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL rst_pending: got %0h want 0", Pending); end
      $display("test_reset done");
   endtask

   task automatic test_alu;
      AluWr = 1'b1; AluAddr = 5'd5; AluData = 32'h1234;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b1) begin miscompares++; $display("FAIL alu_regwr: got %0h want 1", RegWr); end
      vectors++; if (WrAddr !== 5'd5) begin miscompares++; $display("FAIL alu_wraddr: got %0d want 5", WrAddr); end
      vectors++; if (DataIn !== 32'h1234) begin miscompares++; $display("FAIL alu_datain: got %0h want 1234", DataIn); end
      AluWr = 1'b0;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL alu_idle_regwr: got %0h want 0", RegWr); end
      vectors++; if (WrAddr !== 5'd5) begin miscompares++; $display("FAIL alu_idle_hold: got %0d want 5", WrAddr); end
      AluWr = 1'b1; AluAddr = 5'd0; AluData = 32'hDEAD;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL alu_addr0_regwr: got %0h want 0", RegWr); end
      vectors++; if (DataIn !== 32'h1234) begin miscompares++; $display("FAIL alu_addr0_hold: got %0h want 1234", DataIn); end
      AluWr = 1'b0;
      $display("test_alu done");
   endtask

   task automatic test_fill_drain;
      AluWr = 1'b1; AluAddr = 5'd20; AluData = 32'h55;
      for (int k = 1; k <= 4; k++) begin
         MemWr = 1'b1; MemAddr = 5'(k); MemData = 32'hA0 + 32'(k);
         @(negedge Clk);
         vectors++; if (Count !== 3'(k)) begin miscompares++; $display("FAIL fill_count%0d: got %0d want %0d", k, Count, k); end
         vectors++; if (MemReady !== (k < 4)) begin miscompares++; $display("FAIL fill_ready%0d: got %0h want %0h", k, MemReady, (k < 4)); end
         vectors++; if (WrAddr !== 5'd20) begin miscompares++; $display("FAIL fill_alu%0d: got %0d want 20", k, WrAddr); end
      end
      MemAddr = 5'd5; MemData = 32'hA5;
      @(negedge Clk);
      QueryAddr = 5'd5;
      #1;
      vectors++; if (Count !== 3'd4) begin miscompares++; $display("FAIL fifth_count: got %0d want 4", Count); end
      vectors++; if (MemReady !== 1'b0) begin miscompares++; $display("FAIL fifth_ready: got %0h want 0", MemReady); end
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL fifth_pending: got %0h want 0", Pending); end
      MemWr = 1'b0; AluWr = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         vectors++; if (RegWr !== 1'b1) begin miscompares++; $display("FAIL drain_regwr%0d: got %0h want 1", k, RegWr); end
         vectors++; if (WrAddr !== 5'(k)) begin miscompares++; $display("FAIL drain_addr%0d: got %0d want %0d", k, WrAddr, k); end
         vectors++; if (DataIn !== 32'hA0 + 32'(k)) begin miscompares++; $display("FAIL drain_data%0d: got %0h want %0h", k, DataIn, 32'hA0 + 32'(k)); end
         vectors++; if (Count !== 3'(4 - k)) begin miscompares++; $display("FAIL drain_count%0d: got %0d want %0d", k, Count, 4 - k); end
         vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL drain_ready%0d: got %0h want 1", k, MemReady); end
      end
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL drain_end: got %0h want 0", RegWr); end
      // Refill after wrap: push 11 then 12; 11 is written two cycles after its push.
      MemWr = 1'b1; MemAddr = 5'd11; MemData = 32'hB1;
      @(negedge Clk);
      vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL refill_count1: got %0d want 1", Count); end
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL refill_nobypass: got %0h want 0", RegWr); end
      MemAddr = 5'd12; MemData = 32'hB2;
      @(negedge Clk);
      vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL refill_count2: got %0d want 1", Count); end
      vectors++; if (WrAddr !== 5'd11 || DataIn !== 32'hB1 || RegWr !== 1'b1) begin miscompares++; $display("FAIL refill_w11: got %0d/%0h/%0h want 11/b1/1", WrAddr, DataIn, RegWr); end
      MemWr = 1'b0;
      @(negedge Clk);
      vectors++; if (WrAddr !== 5'd12 || DataIn !== 32'hB2 || RegWr !== 1'b1) begin miscompares++; $display("FAIL refill_w12: got %0d/%0h/%0h want 12/b2/1", WrAddr, DataIn, RegWr); end
      vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL refill_count3: got %0d want 0", Count); end
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL refill_end: got %0h want 0", RegWr); end
      $display("test_fill_drain done");
   endtask

   task automatic test_squash;
      AluWr = 1'b1; AluAddr = 5'd20; AluData = 32'h66;
      MemWr = 1'b1; MemAddr = 5'd7; MemData = 32'hBB;
      QueryAddr = 5'd7;
      @(negedge Clk);
      vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL sq_count1: got %0d want 1", Count); end
      MemWr = 1'b0; AluAddr = 5'd7; AluData = 32'hCC;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b1 || WrAddr !== 5'd7 || DataIn !== 32'hCC) begin miscompares++; $display("FAIL sq_alu: got %0h/%0d/%0h want 1/7/cc", RegWr, WrAddr, DataIn); end
      vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL sq_count2: got %0d want 1", Count); end
      vectors++; if (Pending !== 1'b1) begin miscompares++; $display("FAIL sq_pending1: got %0h want 1", Pending); end
      AluWr = 1'b0;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL sq_pop_regwr: got %0h want 0", RegWr); end
      vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL sq_pop_count: got %0d want 0", Count); end
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL sq_pending2: got %0h want 0", Pending); end
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0 || DataIn !== 32'hCC) begin miscompares++; $display("FAIL sq_after: got %0h/%0h want 0/cc", RegWr, DataIn); end
      $display("test_squash done");
   endtask

   task automatic test_push_pop;
      AluWr = 1'b1; AluAddr = 5'd30; AluData = 32'h77;
      MemWr = 1'b1; MemAddr = 5'd21; MemData = 32'hD1;
      @(negedge Clk);
      MemAddr = 5'd22; MemData = 32'hD2;
      @(negedge Clk);
      vectors++; if (Count !== 3'd2) begin miscompares++; $display("FAIL pp_count2: got %0d want 2", Count); end
      MemAddr = 5'd0; MemData = 32'hFF;
      @(negedge Clk);
      vectors++; if (Count !== 3'd2) begin miscompares++; $display("FAIL pp_addr0: got %0d want 2", Count); end
      AluWr = 1'b0; MemAddr = 5'd23; MemData = 32'hD3;
      @(negedge Clk);
      vectors++; if (Count !== 3'd2) begin miscompares++; $display("FAIL pp_same: got %0d want 2", Count); end
      vectors++; if (WrAddr !== 5'd21 || DataIn !== 32'hD1) begin miscompares++; $display("FAIL pp_w21: got %0d/%0h want 21/d1", WrAddr, DataIn); end
      MemWr = 1'b0;
      @(negedge Clk);
      vectors++; if (WrAddr !== 5'd22 || DataIn !== 32'hD2 || Count !== 3'd1) begin miscompares++; $display("FAIL pp_w22: got %0d/%0h/%0d want 22/d2/1", WrAddr, DataIn, Count); end
      @(negedge Clk);
      vectors++; if (WrAddr !== 5'd23 || DataIn !== 32'hD3 || Count !== 3'd0) begin miscompares++; $display("FAIL pp_w23: got %0d/%0h/%0d want 23/d3/0", WrAddr, DataIn, Count); end
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b0) begin miscompares++; $display("FAIL pp_end: got %0h want 0", RegWr); end
      $display("test_push_pop done");
   endtask

   task automatic test_pending;
      QueryAddr = 5'd9;
      AluWr = 1'b1; AluAddr = 5'd10; AluData = 32'h1;
      MemWr = 1'b1; MemAddr = 5'd9; MemData = 32'h99;
      #1;
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL pend_ignore_in: got %0h want 0", Pending); end
      @(negedge Clk);
      vectors++; if (Pending !== 1'b1) begin miscompares++; $display("FAIL pend_queued: got %0h want 1", Pending); end
      QueryAddr = 5'd0;
      #1;
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL pend_q0: got %0h want 0", Pending); end
      QueryAddr = 5'd9; MemWr = 1'b0; AluWr = 1'b0;
      @(negedge Clk);
      vectors++; if (RegWr !== 1'b1 || WrAddr !== 5'd9 || Pending !== 1'b1) begin miscompares++; $display("FAIL pend_writing: got %0h/%0d/%0h want 1/9/1", RegWr, WrAddr, Pending); end
      @(negedge Clk);
      vectors++; if (Pending !== 1'b0) begin miscompares++; $display("FAIL pend_done: got %0h want 0", Pending); end
      AluWr = 1'b1; AluAddr = 5'd10;
      MemWr = 1'b1; MemAddr = 5'd9; MemData = 32'h98;
      @(negedge Clk);
      vectors++; if (Pending !== 1'b1) begin miscompares++; $display("FAIL pend_q2: got %0h want 1", Pending); end
      MemWr = 1'b0; AluAddr = 5'd9;
      @(negedge Clk);
      vectors++; if (Pending !== 1'b1) begin miscompares++; $display("FAIL pend_sq_alu: got %0h want 1", Pending); end
      AluAddr = 5'd10;
      @(negedge Clk);
      vectors++; if (Pending !== 1'b0 || Count !== 3'd1) begin miscompares++; $display("FAIL pend_sq_gone: got %0h/%0d want 0/1", Pending, Count); end
      AluWr = 1'b0;
      @(negedge Clk);
      vectors++; if (Count !== 3'd0 || RegWr !== 1'b0) begin miscompares++; $display("FAIL pend_sq_pop: got %0d/%0h want 0/0", Count, RegWr); end
      $display("test_pending done");
   endtask

   task automatic test_reset_mid;
      AluWr = 1'b1; AluAddr = 5'd10; AluData = 32'h42;
      for (int k = 1; k <= 3; k++) begin
         MemWr = 1'b1; MemAddr = 5'(k); MemData = 32'hC0 + 32'(k);
         @(negedge Clk);
      end
      MemWr = 1'b0; QueryAddr = 5'd2;
      vectors++; if (Count !== 3'd3 || RegWr !== 1'b1) begin miscompares++; $display("FAIL rm_pre: got %0d/%0h want 3/1", Count, RegWr); end
      #2 Rst = 1'b1; AluWr = 1'b0;
      #1;
      vectors++; if (RegWr !== 1'b0 || WrAddr !== 5'd0 || DataIn !== 32'd0) begin miscompares++; $display("FAIL rm_out: got %0h/%0d/%0h want 0/0/0", RegWr, WrAddr, DataIn); end
      vectors++; if (Count !== 3'd0 || MemReady !== 1'b1 || Pending !== 1'b0) begin miscompares++; $display("FAIL rm_state: got %0d/%0h/%0h want 0/1/0", Count, MemReady, Pending); end
      @(negedge Clk);
      Rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         vectors++; if (RegWr !== 1'b0 || Count !== 3'd0 || MemReady !== 1'b1) begin miscompares++; $display("FAIL rm_after%0d: got %0h/%0d/%0h want 0/0/1", k, RegWr, Count, MemReady); end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      Rst = 1'b1;
      AluWr = 1'b0; AluAddr = 5'd0; AluData = 32'd0;
      MemWr = 1'b0; MemAddr = 5'd0; MemData = 32'd0;
      QueryAddr = 5'd5;
      @(negedge Clk);
      @(negedge Clk);
      test_reset();
      Rst = 1'b0;
      test_alu();
      test_fill_drain();
      test_squash();
      test_push_pop();
      test_pending();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
